vpg_pattern_engine: RTL and testbench
=====================================

# vpg_pattern_engine

Parametrised multi-mode successor to the video pattern generator in the DVI video-pattern-generator (VPG) path. It sits between the sync/timing generator and the DVI transmitter. It takes the timing stream (DE/HS/VS plus X/Y coordinates) and produces RGB at configurable colour depth. Five selectable test patterns are provided, and they can optionally be animated frame by frame.

## Interface
- COLOR_W, 8: bits per colour channel
- COORD_W, 12: width of pixel coordinates and image dimensions
- CHECK_LOG2, 5: checker square edge = 2^CHECK_LOG2 pixels
- BOX_LOG2, 6: moving box edge = 2^BOX_LOG2 pixels
- FCNT_W, 8: frame counter width
- pixel_clk  in  1  pixel clock; the only clock
- reset  in  1  synchronous, active-high reset
- pixel_de / pixel_hs / pixel_vs  in  1 each  timing in; HS/VS active-low
- pixel_x, pixel_y  in  COORD_W  current coordinate, valid when pixel_de=1
- image_width, image_height  in  COORD_W  active area size
- mode  in  3  0 ramp, 1 colour bars, 2 checker, 3 moving box, 4 solid white; 5-7 behave as 0
- anim_en  in  1  enable per-frame animation
- gen_de / gen_hs / gen_vs  out  1 each  timing, delayed to match RGB
- gen_r, gen_g, gen_b  out  COLOR_W each  pixel colour
- gen_x, gen_y  out  COORD_W  delayed coordinates
- frame_cnt  out  FCNT_W  frames seen since reset, wraps

## Operation
- **Frame start** = falling edge of pixel_vs, detected with a 1-bit registered copy of VS.
- **At frame start:**
  - mode and anim_en are latched into act_mode/act_anim.
  - frame_cnt increments, wrapping at 2^FCNT_W-1 → 0.
  - Box position updates if act_anim is set.
- Inputs changed mid-frame have no effect until the next frame start.
- **pixel_de=0:** RGB = 0 in every mode.
- **Mode 0 (ramp):**
  - Border pixels (x==0, x+1==width, y==0, y+1==height) are all-ones.
  - Otherwise the screen is split into four horizontal bands at height>>2, height>>1 and their sum: red, green, blue, grey.
  - Level = (pixel_x + (act_anim ? frame_cnt : 0)) truncated to COLOR_W.
- **Mode 1 (bars):** eight vertical bars, left to right: white, yellow, cyan, green, magenta, red, blue, black. Channels are all-ones or 0.
  - Bar width bw = image_width>>3; bw of 0 is treated as 1.
  - Per-line counter: on pixel_de with pixel_x==0, bar_idx=0 and bar_cnt=0.
  - Each DE pixel, bar_cnt increments. When bar_cnt+1==bw, bar_cnt returns to 0 and bar_idx increments, saturating at 7.
- **Mode 2 (checker):**
  - White when bit CHECK_LOG2 of (pixel_x+off) XOR bit CHECK_LOG2 of pixel_y is 1, else black.
  - off = act_anim ? frame_cnt : 0, zero-extended to COORD_W.
- **Mode 3 (box):** white square of edge B=2^BOX_LOG2 at (bx,by) on a black field.
  - Pixel is white when bx ≤ x < bx+B and by ≤ y < by+B.
  - Animation moves the box 1 px per frame on each axis.
  - Each axis reverses direction when its next step would give bx+B > width or bx < 0; same rule for y with height.
  - If the image is smaller than B on an axis, position holds at 0 on that axis.
- **Mode 4:** all channels all-ones inside DE.
- **Reset:**
  - All outputs 0 except gen_hs=gen_vs=1.
  - frame_cnt=0, act_mode=0, act_anim=0, bx=by=0, direction +1 on both axes.
  - Pipeline contents are cleared.

## Timing
- Fixed latency of 2 pixel_clk cycles from pixel_* to gen_*, for every output except frame_cnt.
  - Stage 1 registers the inputs, bar_idx, and per-mode hit flags.
  - Stage 2 registers the colour mux.
- frame_cnt, act_mode and the box position update in the cycle after VS is sampled low while its registered copy was high. They therefore take effect on pixels entering stage 1 from that cycle on.
- Reset is synchronous: an assertion mid-frame forces reset values on the next edge. Outputs resume with valid data 2 cycles after deassertion.
- No back-pressure. One pixel is accepted every cycle.

## Structure
- Package vpg_pkg holds:
  - mode constants (VPG_RAMP … VPG_SOLID)
  - the 8-entry bar colour table, as 3-bit RGB masks expanded to COLOR_W
  - the pipeline latency constant VPG_LAT = 2
- Sub-module vpg_box_tracker (frame-start pulse, anim, width/height → bx, by) holds the bounce logic.

## Test plan
- **Reset mid-frame:** assert reset at x=100 with mode=1 active → next edge RGB=0, gen_hs=gen_vs=1, frame_cnt=0; after release, output is mode 0 ramp.
- **Latency:** 1920×1080, mode 0, pixel (5,1) in red band → gen_r=5, gen_g=gen_b=0, appearing exactly 2 cycles later with gen_x=5; x=0 → all 0xFF.
- **Bars:** width 640 (bw=80), mode 1 → x=79 white, x=80 yellow (FF,FF,00), x=639 black; width 4 → bw=1 and bar_idx saturates at 7.
- **Mode latch:** change mode 2→4 at line 500 → current frame stays checker; the next frame after the VS fall is solid white; frame_cnt rolls 255→0 after 256 frames.
- **Checker animation:** CHECK_LOG2=5, anim_en=1, frame_cnt=32, pixel (0,0) → white; with anim_en=0 → black.
- **Box bounce:** width 128, B=64, anim → bx goes 0..64 then 63; with width 32, bx stays 0 across 10 frames.

Source files
------------

// File: rtl/vpg_pkg.sv
// Shared constants for the video pattern engine: mode encodings, bar colours
// and pipeline depth.
package vpg_pkg;

    typedef enum logic [2:0] {
        VPG_RAMP  = 3'd0,
        VPG_BARS  = 3'd1,
        VPG_CHECK = 3'd2,
        VPG_BOX   = 3'd3,
        VPG_SOLID = 3'd4
    } vpg_mode_e;

    localparam int VPG_LAT = 2;

    // {R,G,B} masks, left to right across the screen.
    localparam logic [2:0] VPG_BAR_RGB [0:7] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

endpackage

// File: rtl/vpg_box_tracker.sv
// Bouncing box position: one pixel per frame on each axis, reversing at the
// image edges, pinned to 0 on an axis too small to hold the box.
module vpg_box_tracker
    import vpg_pkg::*;
#(
    parameter int COORD_W  = 12,
    parameter int BOX_LOG2 = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               anim,
    input  logic [COORD_W-1:0] width,
    input  logic [COORD_W-1:0] height,
    output logic [COORD_W-1:0] bx,
    output logic [COORD_W-1:0] by
);

    localparam logic [COORD_W:0] BOX = (COORD_W+1)'(1) << BOX_LOG2;
    localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

    logic dir_x, dir_y;  // 1 = moving toward 0

    // Returns {new_dir, new_pos}.
    function automatic logic [COORD_W:0] step(input logic [COORD_W-1:0] pos,
                                              input logic dir,
                                              input logic [COORD_W-1:0] lim);
        logic [COORD_W:0] ep, el;
        ep = {1'b0, pos};
        el = {1'b0, lim};
        if (el <= BOX)
            return {dir, {COORD_W{1'b0}}};
        else if (!dir) begin
            if (ep + (COORD_W+1)'(1) + BOX > el) return {1'b1, pos - ONE};
            else                                  return {1'b0, pos + ONE};
        end else begin
            if (pos == '0) return {1'b0, pos + ONE};
            else           return {1'b1, pos - ONE};
        end
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            bx    <= '0;
            by    <= '0;
            dir_x <= 1'b0;
            dir_y <= 1'b0;
        end else if (frame_start && anim) begin
            {dir_x, bx} <= step(bx, dir_x, width);
            {dir_y, by} <= step(by, dir_y, height);
        end
    end

endmodule

// File: rtl/vpg_pattern_engine.sv
// Multi-mode test-pattern generator between the timing generator and the DVI
// transmitter; two-stage pipeline (hit flags, then colour mux).
module vpg_pattern_engine
    import vpg_pkg::*;
#(
    parameter int COLOR_W    = 8,
    parameter int COORD_W    = 12,
    parameter int CHECK_LOG2 = 5,
    parameter int BOX_LOG2   = 6,
    parameter int FCNT_W     = 8
) (
    input  logic               pixel_clk,
    input  logic               reset,
    input  logic               pixel_de,
    input  logic               pixel_hs,
    input  logic               pixel_vs,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    input  logic [COORD_W-1:0] image_width,
    input  logic [COORD_W-1:0] image_height,
    input  logic [2:0]         mode,
    input  logic               anim_en,
    output logic               gen_de,
    output logic               gen_hs,
    output logic               gen_vs,
    output logic [COLOR_W-1:0] gen_r,
    output logic [COLOR_W-1:0] gen_g,
    output logic [COLOR_W-1:0] gen_b,
    output logic [COORD_W-1:0] gen_x,
    output logic [COORD_W-1:0] gen_y,
    output logic [FCNT_W-1:0]  frame_cnt
);

    localparam int TW = 3 + 2*COORD_W;
    localparam logic [TW-1:0] T_IDLE = {3'b011, {(2*COORD_W){1'b0}}};
    localparam logic [COORD_W-1:0] ONE = COORD_W'(1);
    localparam logic [COORD_W:0] BOX = (COORD_W+1)'(1) << BOX_LOG2;

    logic               vs_q, frame_start;
    logic [2:0]         act_mode;
    logic               act_anim;
    logic [FCNT_W-1:0]  fcnt;
    logic [COORD_W-1:0] bx, by;

    assign frame_start = vs_q & ~pixel_vs;
    assign frame_cnt   = fcnt;

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            vs_q     <= 1'b1;
            act_mode <= VPG_RAMP;
            act_anim <= 1'b0;
            fcnt     <= '0;
        end else begin
            vs_q <= pixel_vs;
            if (frame_start) begin
                act_mode <= mode;
                act_anim <= anim_en;
                fcnt     <= fcnt + FCNT_W'(1);
            end
        end
    end

    vpg_box_tracker #(.COORD_W(COORD_W), .BOX_LOG2(BOX_LOG2)) u_box (
        .clk        (pixel_clk),
        .reset      (reset),
        .frame_start(frame_start),
        .anim       (act_anim),
        .width      (image_width),
        .height     (image_height),
        .bx         (bx),
        .by         (by)
    );

    // Per-line bar counter; the x==0 override makes the first pixel of each
    // line land in bar 0 regardless of what the previous line left behind.
    logic [2:0]         bar_idx, cur_idx;
    logic [COORD_W-1:0] bar_cnt, cur_cnt, bw, bw_eff;

    assign bw     = image_width >> 3;
    assign bw_eff = (bw == '0) ? ONE : bw;

    always_comb begin
        cur_idx = bar_idx;
        cur_cnt = bar_cnt;
        if (pixel_x == '0) begin
            cur_idx = '0;
            cur_cnt = '0;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            bar_idx <= '0;
            bar_cnt <= '0;
        end else if (pixel_de) begin
            if (cur_cnt + ONE == bw_eff) begin
                bar_cnt <= '0;
                bar_idx <= (cur_idx == 3'd7) ? cur_idx : cur_idx + 3'd1;
            end else begin
                bar_cnt <= cur_cnt + ONE;
                bar_idx <= cur_idx;
            end
        end
    end

    // Stage 1 hit flags
    logic [COORD_W-1:0] off, xo, q1, q2;
    logic [COORD_W:0]   q3;
    logic               border, chk_hit, box_hit;
    logic [1:0]         band;

    assign off = act_anim ? COORD_W'(fcnt) : '0;
    assign xo  = pixel_x + off;
    assign q1  = image_height >> 2;
    assign q2  = image_height >> 1;
    assign q3  = {1'b0, q1} + {1'b0, q2};

    assign border = (pixel_x == '0) || (pixel_y == '0) ||
                    ({1'b0, pixel_x} + (COORD_W+1)'(1) == {1'b0, image_width}) ||
                    ({1'b0, pixel_y} + (COORD_W+1)'(1) == {1'b0, image_height});

    assign chk_hit = xo[CHECK_LOG2] ^ pixel_y[CHECK_LOG2];

    assign box_hit = ({1'b0, pixel_x} >= {1'b0, bx}) && ({1'b0, pixel_x} < {1'b0, bx} + BOX) &&
                     ({1'b0, pixel_y} >= {1'b0, by}) && ({1'b0, pixel_y} < {1'b0, by} + BOX);

    always_comb begin
        band = 2'd3;
        if (pixel_y < q1)                 band = 2'd0;
        else if (pixel_y < q2)            band = 2'd1;
        else if ({1'b0, pixel_y} < q3)    band = 2'd2;
    end

    logic [VPG_LAT-1:0][TW-1:0] tpipe;
    logic [2:0]                 s1_mode, s1_bar;
    logic [1:0]                 s1_band;
    logic                       s1_border, s1_chk, s1_box;
    logic [COLOR_W-1:0]         s1_lvl;

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            tpipe     <= {VPG_LAT{T_IDLE}};
            s1_mode   <= '0;
            s1_bar    <= '0;
            s1_band   <= '0;
            s1_border <= 1'b0;
            s1_chk    <= 1'b0;
            s1_box    <= 1'b0;
            s1_lvl    <= '0;
        end else begin
            tpipe[0] <= {pixel_de, pixel_hs, pixel_vs, pixel_x, pixel_y};
            for (int i = 1; i < VPG_LAT; i++) tpipe[i] <= tpipe[i-1];
            s1_mode   <= act_mode;
            s1_bar    <= cur_idx;
            s1_band   <= band;
            s1_border <= border;
            s1_chk    <= chk_hit;
            s1_box    <= box_hit;
            s1_lvl    <= COLOR_W'(xo);
        end
    end

    // Stage 2 colour mux
    logic [COLOR_W-1:0] nr, ng, nb;
    logic [2:0]         bar_rgb;
    logic               s1_de;

    assign s1_de   = tpipe[0][TW-1];
    assign bar_rgb = VPG_BAR_RGB[s1_bar];

    always_comb begin
        nr = '0;
        ng = '0;
        nb = '0;
        if (s1_de) begin
            case (s1_mode)
                VPG_BARS:  {nr, ng, nb} = {{COLOR_W{bar_rgb[2]}}, {COLOR_W{bar_rgb[1]}}, {COLOR_W{bar_rgb[0]}}};
                VPG_CHECK: {nr, ng, nb} = {(3*COLOR_W){s1_chk}};
                VPG_BOX:   {nr, ng, nb} = {(3*COLOR_W){s1_box}};
                VPG_SOLID: {nr, ng, nb} = {(3*COLOR_W){1'b1}};
                default: begin
                    if (s1_border) {nr, ng, nb} = {(3*COLOR_W){1'b1}};
                    else begin
                        case (s1_band)
                            2'd0:    nr = s1_lvl;
                            2'd1:    ng = s1_lvl;
                            2'd2:    nb = s1_lvl;
                            default: {nr, ng, nb} = {s1_lvl, s1_lvl, s1_lvl};
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            gen_r <= '0;
            gen_g <= '0;
            gen_b <= '0;
        end else begin
            gen_r <= nr;
            gen_g <= ng;
            gen_b <= nb;
        end
    end

    assign {gen_de, gen_hs, gen_vs, gen_x, gen_y} = tpipe[VPG_LAT-1];

endmodule

// File: tb/tb_vpg_pattern_engine.sv
// Scoreboard bench: randomized timing/mode stimulus, expected pixels from a
// frame-level reference model, checked by an independent monitor.
`timescale 1ns/1ps
module tb_vpg_pattern_engine;

    localparam int CW = 8, XW = 12, CL = 5, BL = 6, FW = 8;
    localparam int BE = 1 << BL;
    localparam int HB = 4;

    logic          pixel_clk = 1'b0;
    logic          reset = 1'b1;
    logic          pixel_de = 1'b0, pixel_hs = 1'b1, pixel_vs = 1'b1;
    logic [XW-1:0] pixel_x = '0, pixel_y = '0, image_width = '0, image_height = '0;
    logic [2:0]    mode = '0;
    logic          anim_en = 1'b0;
    logic          gen_de, gen_hs, gen_vs;
    logic [CW-1:0] gen_r, gen_g, gen_b;
    logic [XW-1:0] gen_x, gen_y;
    logic [FW-1:0] frame_cnt;

    vpg_pattern_engine #(.COLOR_W(CW), .COORD_W(XW), .CHECK_LOG2(CL), .BOX_LOG2(BL), .FCNT_W(FW)) dut (
        .pixel_clk(pixel_clk), .reset(reset),
        .pixel_de(pixel_de), .pixel_hs(pixel_hs), .pixel_vs(pixel_vs),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .image_width(image_width), .image_height(image_height),
        .mode(mode), .anim_en(anim_en),
        .gen_de(gen_de), .gen_hs(gen_hs), .gen_vs(gen_vs),
        .gen_r(gen_r), .gen_g(gen_g), .gen_b(gen_b),
        .gen_x(gen_x), .gen_y(gen_y), .frame_cnt(frame_cnt)
    );

    always #5 pixel_clk = ~pixel_clk;

    int cyc = 0;
    always @(posedge pixel_clk) cyc <= cyc + 1;

    typedef struct packed {
        logic          de, hs, vs;
        logic [XW-1:0] x, y;
        logic [CW-1:0] r, g, b;
    } obs_t;
    typedef struct { int due; obs_t exp; } ent_t;
    typedef struct { int due; int fc; } fent_t;

    localparam obs_t IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1, default: '0};

    ent_t  q[$];
    fent_t fq[$];
    int    n_cmp = 0, n_bad = 0;
    logic  final_chk = 1'b0;

    // Reference model state, one update per frame start
    int m_mode, m_anim, m_fc, m_bx, m_by, m_dx, m_dy;
    logic m_pvs;

    task automatic model_reset();
        m_mode = 0; m_anim = 0; m_fc = 0;
        m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
        m_pvs = 1'b1;
    endtask

    task automatic box_step(inout int p, inout int d, input int lim);
        int n;
        if (lim <= BE) begin p = 0; return; end
        n = p + d;
        if (n < 0 || n + BE > lim) begin d = -d; n = p + d; end
        p = n;
    endtask

    task automatic model_frame_start();
        if (m_anim != 0) begin
            box_step(m_bx, m_dx, int'(image_width));
            box_step(m_by, m_dy, int'(image_height));
        end
        m_anim = int'(anim_en);
        m_mode = int'(mode);
        m_fc   = (m_fc + 1) % 256;
    endtask

    function automatic logic [2:0] bar_mask(input int idx);
        case (idx)
            0: return 3'b111;  1: return 3'b110;  2: return 3'b011;  3: return 3'b010;
            4: return 3'b101;  5: return 3'b100;  6: return 3'b001;  default: return 3'b000;
        endcase
    endfunction

    function automatic logic [23:0] model_rgb(input logic de, input int x, input int y);
        int W, H, off, lvl, bw, idx;
        logic [2:0] m;
        logic [7:0] l8;
        W = int'(image_width);
        H = int'(image_height);
        if (!de) return 24'h0;
        off = (m_anim != 0) ? m_fc : 0;
        case (m_mode)
            1: begin
                bw = W / 8;
                if (bw == 0) bw = 1;
                idx = x / bw;
                if (idx > 7) idx = 7;
                m = bar_mask(idx);
                return {{8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
            end
            2: return (((((x + off) % 4096) >> CL) ^ (y >> CL)) & 1) != 0 ? 24'hFFFFFF : 24'h0;
            3: return (x >= m_bx && x < m_bx + BE && y >= m_by && y < m_by + BE) ? 24'hFFFFFF : 24'h0;
            4: return 24'hFFFFFF;
            default: begin
                if (x == 0 || x + 1 == W || y == 0 || y + 1 == H) return 24'hFFFFFF;
                lvl = (x + off) % 256;
                l8  = 8'(lvl);
                if (y < H / 4)               return {l8, 16'h0};
                else if (y < H / 2)          return {8'h0, l8, 8'h0};
                else if (y < H / 4 + H / 2)  return {16'h0, l8};
                else                         return {l8, l8, l8};
            end
        endcase
    endfunction

    task automatic drive(input logic de, input logic hs, input logic vs,
                         input int x, input int y, input logic rst);
        ent_t  e;
        fent_t f;
        @(posedge pixel_clk);
        #1;
        reset = rst; pixel_de = de; pixel_hs = hs; pixel_vs = vs;
        pixel_x = XW'(x); pixel_y = XW'(y);
        e.due = cyc + 2;
        if (rst) begin
            if (q.size() > 0 && q[q.size()-1].due == cyc + 1) q[q.size()-1].exp = IDLE;
            e.exp = IDLE;
            model_reset();
        end else begin
            if (x == 0) begin
                f.due = cyc; f.fc = m_fc;
                fq.push_back(f);
            end
            e.exp = {de, hs, vs, XW'(x), XW'(y), model_rgb(de, x, y)};
            if (m_pvs && !vs) model_frame_start();
            m_pvs = vs;
        end
        q.push_back(e);
    endtask

    // One frame: a VS-low line, two blank lines, then vact active lines.
    task automatic run_frame(input int W, input int H, input int hact, input int vact,
                             input int md, input int an,
                             input int chg_line = -1, input int chg_md = 0,
                             input int rst_line = -1, input int rst_x = 0);
        image_width = XW'(W); image_height = XW'(H);
        mode = 3'(md); anim_en = an[0];
        for (int v = 0; v < vact + 3; v++) begin
            for (int h = 0; h < hact + HB; h++) begin
                int y;
                logic act, de, hs, vs, rst;
                act = (v >= 3);
                y   = act ? v - 3 : 0;
                de  = act && (h < hact);
                hs  = !(h == hact + 1 || h == hact + 2);
                vs  = (v != 0);
                rst = act && (y == rst_line) && (h == rst_x || h == rst_x + 1);
                if (act && y == chg_line && h == 0) mode = 3'(chg_md);
                drive(de, hs, vs, h, y, rst);
            end
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectation.
    always @(negedge pixel_clk) begin : monitor
        ent_t  e;
        fent_t f;
        obs_t  a;
        if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            a = {gen_de, gen_hs, gen_vs, gen_x, gen_y, gen_r, gen_g, gen_b};
            n_cmp++;
            if (e.due != cyc || a !== e.exp) begin
                n_bad++;
                if (n_bad <= 40)
                    $display("FAIL pixel cyc=%0d got de=%b hs=%b vs=%b x=%0d y=%0d rgb=%h_%h_%h want de=%b hs=%b vs=%b x=%0d y=%0d rgb=%h_%h_%h",
                             cyc, a.de, a.hs, a.vs, a.x, a.y, a.r, a.g, a.b,
                             e.exp.de, e.exp.hs, e.exp.vs, e.exp.x, e.exp.y, e.exp.r, e.exp.g, e.exp.b);
            end
        end
        if (fq.size() > 0 && fq[0].due <= cyc) begin
            f = fq.pop_front();
            n_cmp++;
            if (f.due != cyc || frame_cnt !== FW'(f.fc)) begin
                n_bad++;
                if (n_bad <= 40) $display("FAIL frame_cnt cyc=%0d got %0d want %0d", cyc, frame_cnt, f.fc);
            end
        end
        if (final_chk) begin
            final_chk <= 1'b0;
            n_cmp++;
            if (q.size() != 0 || fq.size() != 0) begin
                n_bad++;
                $display("FAIL drain got %0d pending want 0", q.size() + fq.size());
            end
        end
    end

    initial begin
        int W, H, md, hact, an;
        model_reset();
        repeat (4) drive(1'b0, 1'b1, 1'b1, 0, 0, 1'b1);

        // Latency / ramp on a 1920x1080 image, three short lines
        run_frame(1920, 1080, 8, 3, 0, 0);
        // Bars: bw=80, then bw clamped to 1 with saturation beyond x=7
        run_frame(640, 4, 640, 2, 1, 0);
        run_frame(4, 4, 16, 2, 1, 0);

        // Random frames with mid-frame mode changes that must not take effect
        for (int i = 0; i < 8; i++) begin
            W = 16 + int'($urandom % 57);
            H = 6 + int'($urandom % 11);
            run_frame(W, H, W, H, int'($urandom % 8), int'($urandom % 2),
                      int'($urandom % H), int'($urandom % 8));
        end

        // Reset mid-line of a bars frame, then a plain ramp frame
        run_frame(160, 8, 160, 4, 1, 0, -1, 0, 1, 100);
        run_frame(48, 8, 48, 8, 0, 1);

        // Long animated run: frame counter wrap, box bounce, checker offset
        for (int f = 0; f < 270; f++) begin
            W  = (f >= 100 && f < 110) ? 32 : 128;
            md = (f % 7 == 0) ? 4 : (f % 5 == 0) ? 0 : (f % 3 == 0) ? 2 : 3;
            an = (f >= 200 && f < 210) ? 0 : 1;
            hact = (f % 8 == 0 || (m_bx >= 62 && m_bx <= 65)) ? W : 8;
            if (m_fc == 31 || f == 205) begin md = 2; hact = W; end
            run_frame(W, 96, hact, 2, md, an);
        end

        repeat (4) drive(1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
        repeat (4) @(posedge pixel_clk);
        #1 final_chk = 1'b1;
        @(posedge pixel_clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
